// File: rtl/neuron_backward_pkg.sv
// -----------------------------------------------------------------------------
// neuron_backward_pkg
// Shared definitions for the neuron backward-pass block:
//   - state_e      : FSM states of the backward-pass sequencer
//   - Q_W / Q_FRAC : width and fractional bits of the signed Q8.8 format
//   - SAT_MAX/MIN  : 16-bit saturation limits (and their 32-bit forms)
//   - sat16()      : clamp a 32-bit signed value into the 16-bit range
// -----------------------------------------------------------------------------
package neuron_backward_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam int Q_W    = 16;
   localparam int Q_FRAC = 8;
   localparam int PROD_W = 2 * Q_W;

   localparam logic signed [Q_W-1:0]    SAT_MAX    = 16'sh7FFF;
   localparam logic signed [Q_W-1:0]    SAT_MIN    = 16'sh8000;
   localparam logic signed [PROD_W-1:0] SAT_MAX_32 = 32'sh0000_7FFF;
   localparam logic signed [PROD_W-1:0] SAT_MIN_32 = 32'shFFFF_8000;

   // Clamp a full-width signed value into the 16-bit signed range.
   function automatic logic signed [Q_W-1:0] sat16(input logic signed [PROD_W-1:0] v);
      logic signed [Q_W-1:0] r;
      if (v > SAT_MAX_32) begin
         r = SAT_MAX;
      end else if (v < SAT_MIN_32) begin
         r = SAT_MIN;
      end else begin
         r = v[Q_W-1:0];
      end
      return r;
   endfunction

endpackage : neuron_backward_pkg

// File: rtl/neuron_backward_grad_mul.sv
// -----------------------------------------------------------------------------
// grad_mul
// Combinational multiply / arithmetic-shift / saturate for one gradient path:
//   p_o = sat16((a_i * b_i) >>> FRAC)
// Ports:
//   a_i : signed 16-bit operand (effective gradient)
//   b_i : signed 16-bit operand (forward input or weight)
//   p_o : signed 16-bit saturated Q-format product
// -----------------------------------------------------------------------------
module grad_mul
   import neuron_backward_pkg::*;
#(
   parameter int FRAC = Q_FRAC
) (
   input  logic signed [Q_W-1:0] a_i,
   input  logic signed [Q_W-1:0] b_i,
   output logic signed [Q_W-1:0] p_o
);

   logic signed [PROD_W-1:0] prod_s;
   logic signed [PROD_W-1:0] shift_s;

   // Full-precision product; the shift floors toward minus infinity.
   assign prod_s  = a_i * b_i;
   assign shift_s = prod_s >>> FRAC;
   assign p_o     = sat16(shift_s);

endmodule : grad_mul

// File: rtl/neuron_backward.sv
// -----------------------------------------------------------------------------
// neuron_backward
// Backward pass of a single ReLU neuron over N streamed x/w element pairs.
// A start pulse latches the ReLU-gated upstream gradient g_eff and sets the
// bias gradient db. Each accepted x/w pair then yields dw = g_eff*x and
// dx = g_eff*w (Q-format, floored, saturated) one cycle later.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : one-cycle pulse beginning a pass (honoured in IDLE only)
//   grad, pre_act     : upstream gradient and forward pre-activation
//   in_valid, x, w    : element pair stream (honoured in STREAM only)
//   dx, dw, idx       : per-element gradients and their element index
//   out_valid         : dx/dw/idx carry a new result this cycle
//   db                : bias gradient, held until the next start
//   busy, done        : pass in progress; pulse with the last element's result
// -----------------------------------------------------------------------------
module neuron_backward
   import neuron_backward_pkg::*;
#(
   parameter int N    = 4,
   parameter int FRAC = Q_FRAC
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic signed [Q_W-1:0]    grad,
   input  logic signed [Q_W-1:0]    pre_act,
   input  logic                     in_valid,
   input  logic signed [Q_W-1:0]    x,
   input  logic signed [Q_W-1:0]    w,
   output logic signed [Q_W-1:0]    dx,
   output logic signed [Q_W-1:0]    dw,
   output logic [$clog2(N)-1:0]     idx,
   output logic                     out_valid,
   output logic signed [Q_W-1:0]    db,
   output logic                     busy,
   output logic                     done
);

   localparam int                IDX_W    = $clog2(N);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic signed [Q_W-1:0]   g_eff_q, g_eff_d;
   logic signed [Q_W-1:0]   db_q, db_d;
   logic signed [Q_W-1:0]   dx_q, dx_d;
   logic signed [Q_W-1:0]   dw_q, dw_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    out_valid_q, out_valid_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;

   logic signed [Q_W-1:0]   g_relu_s;
   logic signed [Q_W-1:0]   dx_s;
   logic signed [Q_W-1:0]   dw_s;

   // ReLU derivative: zero pre-activation counts as inactive.
   assign g_relu_s = (pre_act > 16'sd0) ? grad : {Q_W{1'b0}};

   grad_mul #(.FRAC(FRAC)) u_mul_dw (
      .a_i (g_eff_q),
      .b_i (x),
      .p_o (dw_s)
   );

   grad_mul #(.FRAC(FRAC)) u_mul_dx (
      .a_i (g_eff_q),
      .b_i (w),
      .p_o (dx_s)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= {IDX_W{1'b0}};
         g_eff_q     <= {Q_W{1'b0}};
         db_q        <= {Q_W{1'b0}};
         dx_q        <= {Q_W{1'b0}};
         dw_q        <= {Q_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         g_eff_q     <= g_eff_d;
         db_q        <= db_d;
         dx_q        <= dx_d;
         dw_q        <= dw_d;
         idx_q       <= idx_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output logic of the pass sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      g_eff_d     = g_eff_q;
      db_d        = db_q;
      dx_d        = dx_q;
      dw_d        = dw_q;
      idx_d       = idx_q;
      out_valid_d = 1'b0;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               g_eff_d = g_relu_s;
               db_d    = g_relu_s;
               cnt_d   = {IDX_W{1'b0}};
               state_d = ST_STREAM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            if (in_valid) begin
               dx_d        = dx_s;
               dw_d        = dw_s;
               idx_d       = cnt_q;
               out_valid_d = 1'b1;
               // The counter stops at the last index rather than wrapping.
               if (cnt_q == LAST_IDX) begin
                  done_d  = 1'b1;
                  state_d = ST_FINISH;
               end else begin
                  cnt_d   = cnt_q + IDX_W'(1);
                  state_d = ST_STREAM;
               end
            end else begin
               state_d = ST_STREAM;
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered so that busy tracks the state register exactly.
      busy_d = (state_d != ST_IDLE);
   end

   assign dx        = dx_q;
   assign dw        = dw_q;
   assign idx       = idx_q;
   assign out_valid = out_valid_q;
   assign db        = db_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule : neuron_backward
